// File: rtl/card_shoe_dealer_pkg.sv
// Shared types and constants for the card shoe dealer: mode codes, FSM states,
// scripted deal tables and the rank-to-card-value mapping.
package card_pkg;

  localparam int NUM_RANKS  = 13;
  localparam int RW         = 6;  // per-rank counter width, holds up to 4*8 = 32
  localparam int SCRIPT_MAX = 5;

  localparam logic [2:0] MODE_RANDOM    = 3'b000;
  localparam logic [2:0] MODE_SIMPLE    = 3'b001;
  localparam logic [2:0] MODE_DOUBLE    = 3'b010;
  localparam logic [2:0] MODE_BLACKJACK = 3'b011;
  localparam logic [2:0] MODE_SPLIT     = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REFILL, ST_DRAW1, ST_DRAW2, ST_DONE
  } state_t;

  // Rows are indexed by mode-1: simple, double, blackjack, split.
  localparam logic [3:0] SCRIPT_C1 [4][SCRIPT_MAX] = '{
    '{4'd10, 4'd4, 4'd4, 4'd0, 4'd0},
    '{4'd10, 4'd4, 4'd2, 4'd0, 4'd0},
    '{4'd10, 4'd8, 4'd0, 4'd0, 4'd0},
    '{4'd10, 4'd8, 4'd4, 4'd8, 4'd2}
  };
  localparam logic [3:0] SCRIPT_C2 [4][SCRIPT_MAX] = '{
    '{4'd8,  4'd6, 4'd0, 4'd0, 4'd0},
    '{4'd8,  4'd6, 4'd0, 4'd0, 4'd0},
    '{4'd1,  4'd9, 4'd0, 4'd0, 4'd0},
    '{4'd10, 4'd0, 4'd0, 4'd0, 4'd0}
  };
  localparam logic [2:0] SCRIPT_LEN [4] = '{3'd3, 3'd3, 3'd3, 3'd5};

  // Rank 0 is the ace (value 1); ranks 9..12 (ten, J, Q, K) all score 10.
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    return (rank >= 4'd9) ? 4'd10 : rank + 4'd1;
  endfunction

  function automatic logic [3:0] fold_rank(input logic [3:0] raw);
    return (raw >= 4'd13) ? raw - 4'd13 : raw;
  endfunction

endpackage

// File: rtl/card_shoe_dealer_if.sv
// Request/response bundle between the game-control FSM (master) and the dealer (slave).
// Handshake: a request (shuffle_req or deal_req) is taken on the rising clk edge where
// ready=1; the dealer then drops ready until it returns to idle, and a deal completes
// with a single-cycle card_valid pulse. Requests seen while ready=0 are ignored.
interface card_shoe_dealer_if
  import card_pkg::*;
  #(parameter int CW = 9) ();

  logic [2:0]    mode;
  logic          deal_req;
  logic          deal_two;
  logic          shuffle_req;
  logic          ready;
  logic          card_valid;
  logic [3:0]    card1_out;
  logic [3:0]    card2_out;
  logic [CW-1:0] cards_left;
  logic          shoe_low;
  logic          script_done;
  state_t        dbg_state;

  modport master (
    output mode, deal_req, deal_two, shuffle_req,
    input  ready, card_valid, card1_out, card2_out, cards_left, shoe_low,
           script_done, dbg_state
  );

  modport slave (
    input  mode, deal_req, deal_two, shuffle_req,
    output ready, card_valid, card1_out, card2_out, cards_left, shoe_low,
           script_done, dbg_state
  );

endinterface

// File: rtl/card_shoe_dealer_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only while enabled.
module card_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/card_shoe_dealer.sv
// Multi-deck shoe dealer: draws ranks via LFSR with linear probing so no rank exceeds
// its population, refills on empty, and replays fixed scripts in the test modes.
module card_shoe_dealer
  import card_pkg::*;
#(
  parameter int          NUM_DECKS    = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          RESHUFFLE_AT = 15,
  parameter int          CW           = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  card_shoe_dealer_if.slave   bus
);

  localparam logic [RW-1:0] RANK_FULL = RW'(4 * NUM_DECKS);
  localparam logic [CW-1:0] SHOE_FULL = CW'(52 * NUM_DECKS);

  state_t        state_q, state_d, ret_q, ret_d;
  logic [RW-1:0] count_q [NUM_RANKS];
  logic [CW-1:0] left_q;
  logic [15:0]   lfsr;
  logic [3:0]    probe_q, val1_q, card1_q, card2_q;
  logic          first_q, two_q, sd_q;
  logic [2:0]    idx_q, last_mode_q;

  logic [3:0]    cand, draw_val;
  logic          hit, mode_chg, scripted;
  logic [2:0]    eff_idx;
  logic [1:0]    sidx;
  logic          unused_lfsr;

  card_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q != ST_IDLE),
    .state   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:4];

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cand     = first_q ? fold_rank(lfsr[3:0]) : probe_q;
    hit      = (count_q[cand] != '0);
    draw_val = rank_value(cand);
    mode_chg = (bus.mode != last_mode_q);
    eff_idx  = mode_chg ? 3'd0 : idx_q;
    scripted = (bus.mode >= MODE_SIMPLE) && (bus.mode <= MODE_SPLIT);
    sidx     = bus.mode[1:0] - 2'd1;
    case (state_q)
      ST_IDLE: begin
        if (bus.shuffle_req) begin
          state_d = ST_REFILL;
          ret_d   = ST_IDLE;
        end else if (bus.deal_req) begin
          if (bus.mode != MODE_RANDOM) begin
            state_d = ST_DONE;
          end else if (left_q == '0) begin
            state_d = ST_REFILL;
            ret_d   = ST_DRAW1;
          end else begin
            state_d = ST_DRAW1;
          end
        end
      end
      ST_REFILL: state_d = ret_q;
      ST_DRAW1: begin
        if (hit) begin
          if (!two_q) begin
            state_d = ST_DONE;
          end else if (left_q == CW'(1)) begin
            // This hit takes the last card, so the second draw needs a fresh shoe.
            state_d = ST_REFILL;
            ret_d   = ST_DRAW2;
          end else begin
            state_d = ST_DRAW2;
          end
        end
      end
      ST_DRAW2: if (hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      for (int r = 0; r < NUM_RANKS; r++) count_q[r] <= RANK_FULL;
      left_q      <= SHOE_FULL;
      probe_q     <= 4'd0;
      val1_q      <= 4'd0;
      card1_q     <= 4'd0;
      card2_q     <= 4'd0;
      first_q     <= 1'b1;
      two_q       <= 1'b0;
      sd_q        <= 1'b0;
      idx_q       <= 3'd0;
      last_mode_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      // A miss moves the probe to the next rank; anything else rearms the LFSR pick.
      if ((state_q == ST_DRAW1 || state_q == ST_DRAW2) && !hit) begin
        first_q <= 1'b0;
        probe_q <= (cand == 4'd12) ? 4'd0 : cand + 4'd1;
      end else begin
        first_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          last_mode_q <= bus.mode;
          sd_q        <= 1'b0;
          if (mode_chg) idx_q <= 3'd0;
          if (!bus.shuffle_req && bus.deal_req) begin
            two_q <= bus.deal_two;
            if (scripted) begin
              card1_q <= SCRIPT_C1[sidx][eff_idx];
              card2_q <= SCRIPT_C2[sidx][eff_idx];
              if (eff_idx == SCRIPT_LEN[sidx] - 3'd1) begin
                idx_q <= 3'd0;
                sd_q  <= 1'b1;
              end else begin
                idx_q <= eff_idx + 3'd1;
              end
            end else if (bus.mode != MODE_RANDOM) begin
              card1_q <= 4'd0;
              card2_q <= 4'd0;
            end
          end
        end
        ST_REFILL: begin
          for (int r = 0; r < NUM_RANKS; r++) count_q[r] <= RANK_FULL;
          left_q <= SHOE_FULL;
        end
        ST_DRAW1, ST_DRAW2: begin
          if (hit) begin
            count_q[cand] <= count_q[cand] - RW'(1);
            left_q        <= left_q - CW'(1);
            if (state_q == ST_DRAW2) begin
              card1_q <= val1_q;
              card2_q <= draw_val;
            end else if (two_q) begin
              val1_q <= draw_val;
            end else begin
              card1_q <= draw_val;
              card2_q <= 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state_q == ST_IDLE);
  assign bus.card_valid  = (state_q == ST_DONE);
  assign bus.script_done = sd_q && (state_q == ST_DONE);
  assign bus.card1_out   = card1_q;
  assign bus.card2_out   = card2_q;
  assign bus.cards_left  = left_q;
  assign bus.shoe_low    = (left_q < CW'(RESHUFFLE_AT));
  assign bus.dbg_state   = state_q;

endmodule

// File: doc/card_shoe_dealer.md
Name: card_shoe_dealer

Overview:
- Parametrised successor to the game's card source.
- Deals one or two cards per request from a finite multi-deck shoe, so a card rank cannot exceed its real population. An LFSR drives rank selection.
- Retains the deterministic scripted test modes (simple, double, blackjack, split).
- Sits between the game-control FSM, which issues deal requests, and the hand/score logic, which consumes card values 1..10.

Parameters:
- NUM_DECKS, 1: decks in the shoe, 1..8; rank population = 4*NUM_DECKS.
- LFSR_SEED, 16'hACE1: reset seed of the 16-bit LFSR; must be nonzero.
- RESHUFFLE_AT, 15: shoe_low asserts when cards_left < RESHUFFLE_AT.
- CW, 9: width of cards_left; must satisfy 2^CW > 52*NUM_DECKS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  3  000 random, 001 simple, 010 double, 011 blackjack, 100 split, others idle
- deal_req  in  1  request; accepted only when ready=1
- deal_two  in  1  sampled with deal_req: 1 = two cards, 0 = one card
- shuffle_req  in  1  refill shoe to full; accepted only when ready=1
- ready  out  1  high in IDLE only
- card_valid  out  1  one-cycle pulse when a deal completes
- card1_out  out  4  first card value 0..10 (0 = none)
- card2_out  out  4  second card value; 0 when deal_two=0
- cards_left  out  CW  cards remaining in shoe
- shoe_low  out  1  cards_left < RESHUFFLE_AT
- script_done  out  1  one-cycle pulse, coincident with card_valid, when the script index wraps to 0

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all 13 rank counters = 4*NUM_DECKS; cards_left = 52*NUM_DECKS; LFSR = LFSR_SEED
  - card1_out = card2_out = 0; card_valid = script_done = 0
  - script index = 0; state = IDLE; ready = 1
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle the FSM is outside IDLE.
- States:
  - IDLE: shuffle_req has priority over deal_req when both are high.
  - REFILL: one cycle; sets all counters full; returns to IDLE, or to DRAW if entered on an empty shoe mid-deal.
  - DRAW1 / DRAW2: rank selection for card 1 / card 2.
  - DONE: drives card_valid; returns to IDLE.
- Random mode (mode=000) draw procedure:
  - First DRAW cycle: candidate = LFSR[3:0]; values 13..15 fold to 0..2.
  - If count[candidate] = 0: candidate = (candidate+1) mod 13 on the next cycle (linear probe). Worst case 13 cycles per card.
  - On hit: decrement count[candidate] and cards_left; latch value = candidate+1, with ranks 10..12 (J/Q/K) clamped to 10.
  - If cards_left = 0 at DRAW entry: go to REFILL (1 cycle) first, then draw. card_valid is delayed by that cycle; no error is flagged.
  - Latency from accept to card_valid: minimum 2 cycles for one card, 3 cycles for two cards.
- Scripted modes (001..100):
  - Shoe counters and cards_left are untouched.
  - Accept -> DONE; card_valid 1 cycle after accept.
  - Outputs come from the per-mode script table at the current index; the index then advances, wrapping to 0 after the last entry with script_done pulsing.
  - Scripts (card1, card2):
    - simple: (10,8)(4,6)(4,0)
    - double: (10,8)(4,6)(2,0)
    - blackjack: (10,1)(8,9)(0,0)
    - split: (10,10)(8,0)(4,0)(8,0)(2,0)
  - deal_two is ignored in scripted modes.
- Illegal mode (101..111): request accepted; card_valid pulses with 0,0.
- Any change of mode while in IDLE resets the script index to 0.
- mode, deal_req and shuffle_req are ignored while ready=0.
- card1_out and card2_out hold their values until the next card_valid.
- shoe_low is combinational from cards_left.

Decomposition:
- Package card_pkg: mode encodings, state enum, script tables as constant arrays, rank-to-value function, NUM_RANKS=13.
- One natural sub-module: card_lfsr16 (seed, enable, state output).

Test Plan:
- Reset mid-DRAW2 (reset_n low for 1 cycle) -> cards_left=52, outputs 0, ready=1 the cycle after release; no card_valid pulse.
- NUM_DECKS=1, mode=000, 52 single-card deals -> values 1..9 appear exactly 4 times each, 10 appears exactly 16 times; cards_left=0. The 53rd deal takes REFILL, then valid with cards_left=51.
- mode=011 with deal_req, then deal_req again -> card_valid one cycle after each accept with (10,1) then (8,9); cards_left unchanged at 52.
- mode=100 with 5 requests -> (10,10)(8,0)(4,0)(8,0)(2,0); script_done pulses on the 5th; a 6th request returns (10,10).
- Random mode, drain to 14 cards -> shoe_low=1. Assert shuffle_req and deal_req in the same cycle -> REFILL wins, cards_left=52, shoe_low=0, no card_valid.
- Force a single remaining rank (e.g. only rank 12 left) -> the probe finds it within 13 cycles; value output is 10.
